// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants: opcodes, one-hot T-states and control-word bit positions.
package sap1_pkg;

    localparam int unsigned OpWidth = 4;
    localparam int unsigned TWidth  = 6;
    localparam int unsigned CwWidth = 12;

    localparam logic [OpWidth-1:0] OP_LDA = 4'h0;
    localparam logic [OpWidth-1:0] OP_ADD = 4'h1;
    localparam logic [OpWidth-1:0] OP_SUB = 4'h2;
    localparam logic [OpWidth-1:0] OP_OUT = 4'hE;
    localparam logic [OpWidth-1:0] OP_HLT = 4'hF;

    localparam logic [TWidth-1:0] T1 = 6'b000001;
    localparam logic [TWidth-1:0] T2 = 6'b000010;
    localparam logic [TWidth-1:0] T3 = 6'b000100;
    localparam logic [TWidth-1:0] T4 = 6'b001000;
    localparam logic [TWidth-1:0] T5 = 6'b010000;
    localparam logic [TWidth-1:0] T6 = 6'b100000;

    // Bit positions within the control word, also used by the datapath top.
    localparam int unsigned CW_CP  = 0;
    localparam int unsigned CW_EP  = 1;
    localparam int unsigned CW_LM  = 2;
    localparam int unsigned CW_ER  = 3;
    localparam int unsigned CW_EI  = 4;
    localparam int unsigned CW_LA  = 5;
    localparam int unsigned CW_EA  = 6;
    localparam int unsigned CW_SU  = 7;
    localparam int unsigned CW_EU  = 8;
    localparam int unsigned CW_LB  = 9;
    localparam int unsigned CW_LO  = 10;
    localparam int unsigned CW_HLT = 11;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode: maps the current T-state and opcode to the control word.
module ctrl_decode
    import sap1_pkg::*;
#(
    parameter int unsigned OpcodeWidth = 4
) (
    input  logic [TWidth-1:0]      tstate,
    input  logic [OpcodeWidth-1:0] opcode,
    output logic [CwWidth-1:0]     cw_c
);

    always_comb begin
        cw_c = '0;
        unique case (tstate)
            T1: begin
                cw_c[CW_EP] = 1'b1;
                cw_c[CW_LM] = 1'b1;
            end
            T2: cw_c[CW_CP] = 1'b1;
            T3: cw_c[CW_ER] = 1'b1;
            T4: begin
                if (opcode == OpcodeWidth'(OP_LDA) || opcode == OpcodeWidth'(OP_ADD) ||
                    opcode == OpcodeWidth'(OP_SUB)) begin
                    cw_c[CW_EI] = 1'b1;
                    cw_c[CW_LM] = 1'b1;
                end else if (opcode == OpcodeWidth'(OP_OUT)) begin
                    cw_c[CW_EA] = 1'b1;
                    cw_c[CW_LO] = 1'b1;
                end else if (opcode == OpcodeWidth'(OP_HLT)) begin
                    cw_c[CW_HLT] = 1'b1;
                end
            end
            T5: begin
                if (opcode == OpcodeWidth'(OP_LDA)) begin
                    cw_c[CW_ER] = 1'b1;
                    cw_c[CW_LA] = 1'b1;
                end else if (opcode == OpcodeWidth'(OP_ADD) || opcode == OpcodeWidth'(OP_SUB)) begin
                    cw_c[CW_ER] = 1'b1;
                    cw_c[CW_LB] = 1'b1;
                end
            end
            T6: begin
                if (opcode == OpcodeWidth'(OP_ADD) || opcode == OpcodeWidth'(OP_SUB)) begin
                    cw_c[CW_EU] = 1'b1;
                    cw_c[CW_LA] = 1'b1;
                    cw_c[CW_SU] = (opcode == OpcodeWidth'(OP_SUB));
                end
            end
            default: cw_c = '0;
        endcase
    end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 instruction register and six-state ring-counter sequencer with HLT hold.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int unsigned WordWidth    = 8,
    parameter int unsigned OpcodeWidth  = 4,
    parameter int unsigned AddressWidth = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [WordWidth-1:0]    i_bus,
    output logic [AddressWidth-1:0] o_operand,
    output logic                    o_cp,
    output logic                    o_ep,
    output logic                    o_lm,
    output logic                    o_er,
    output logic                    o_ei,
    output logic                    o_la,
    output logic                    o_ea,
    output logic                    o_su,
    output logic                    o_eu,
    output logic                    o_lb,
    output logic                    o_lo,
    output logic                    o_hlt,
    output logic [TWidth-1:0]       o_tstate
);

    if (OpcodeWidth + AddressWidth != WordWidth) begin : g_width_check
        $error("OpcodeWidth + AddressWidth must equal WordWidth");
    end

    logic [TWidth-1:0]      state;
    logic [TWidth-1:0]      state_nxt;
    logic [WordWidth-1:0]   ir;
    logic [OpcodeWidth-1:0] opcode;
    logic [CwWidth-1:0]     cw_c;
    logic [CwWidth-1:0]     cw_gated_c;
    logic                   halt_hold_c;

    assign opcode      = ir[WordWidth-1:AddressWidth];
    assign halt_hold_c = (state == T4) && (opcode == OpcodeWidth'(OP_HLT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= T1;
        end else begin
            state <= state_nxt;
        end
    end

    // Rotate the ring counter every cycle except while parked on HLT.
    always_comb begin
        state_nxt = state;
        if (!halt_hold_c) begin
            state_nxt = {state[TWidth-2:0], state[TWidth-1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ir <= '0;
        end else if (state == T3) begin
            ir <= i_bus;
        end
    end

    ctrl_decode #(
        .OpcodeWidth(OpcodeWidth)
    ) u_ctrl_decode (
        .tstate(state),
        .opcode(opcode),
        .cw_c  (cw_c)
    );

    // Controls are held quiet for the whole time reset is asserted.
    assign cw_gated_c = i_rst_n ? cw_c : '0;

    assign o_cp      = cw_gated_c[CW_CP];
    assign o_ep      = cw_gated_c[CW_EP];
    assign o_lm      = cw_gated_c[CW_LM];
    assign o_er      = cw_gated_c[CW_ER];
    assign o_ei      = cw_gated_c[CW_EI];
    assign o_la      = cw_gated_c[CW_LA];
    assign o_ea      = cw_gated_c[CW_EA];
    assign o_su      = cw_gated_c[CW_SU];
    assign o_eu      = cw_gated_c[CW_EU];
    assign o_lb      = cw_gated_c[CW_LB];
    assign o_lo      = cw_gated_c[CW_LO];
    assign o_hlt     = cw_gated_c[CW_HLT];
    assign o_operand = ir[AddressWidth-1:0];
    assign o_tstate  = state;

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller against an instruction-level SAP-1 sequencing model.
module tb_sap1_controller;

    typedef struct packed {
        logic hlt, lo, lb, eu, su, ea, la, ei, er, lm, ep, cp;
    } cw_t;

    typedef struct packed {
        logic [5:0] ts;
        cw_t        cw;
        logic [3:0] opnd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus = 8'h00;
    logic [3:0] operand;
    logic       cp, ep, lm, er, ei, la, ea, su, eu, lb, lo, hlt;
    logic [5:0] tstate;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q[$];

    // Model state: step number 1..6 within the instruction, and the latched instruction.
    int         m_t  = 1;
    logic [7:0] m_ir = 8'h00;

    sap1_controller #(
        .WordWidth(8),
        .OpcodeWidth(4),
        .AddressWidth(4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_bus    (bus),
        .o_operand(operand),
        .o_cp     (cp),
        .o_ep     (ep),
        .o_lm     (lm),
        .o_er     (er),
        .o_ei     (ei),
        .o_la     (la),
        .o_ea     (ea),
        .o_su     (su),
        .o_eu     (eu),
        .o_lb     (lb),
        .o_lo     (lo),
        .o_hlt    (hlt),
        .o_tstate (tstate)
    );

    always #5 clk = ~clk;

    function automatic cw_t model_cw(int t, logic [3:0] op);
        cw_t c = '0;
        if (t == 1) begin c.ep = 1; c.lm = 1; end
        else if (t == 2) c.cp = 1;
        else if (t == 3) c.er = 1;
        else if (op == 4'h0) begin
            if (t == 4) begin c.ei = 1; c.lm = 1; end
            if (t == 5) begin c.er = 1; c.la = 1; end
        end else if (op == 4'h1 || op == 4'h2) begin
            if (t == 4) begin c.ei = 1; c.lm = 1; end
            if (t == 5) begin c.er = 1; c.lb = 1; end
            if (t == 6) begin c.eu = 1; c.la = 1; c.su = (op == 4'h2); end
        end else if (op == 4'hE) begin
            if (t == 4) begin c.ea = 1; c.lo = 1; end
        end else if (op == 4'hF) begin
            if (t == 4) c.hlt = 1;
        end
        return c;
    endfunction

    function automatic cw_t dut_cw();
        cw_t c;
        c.hlt = hlt; c.lo = lo; c.lb = lb; c.eu = eu; c.su = su; c.ea = ea;
        c.la = la; c.ei = ei; c.er = er; c.lm = lm; c.ep = ep; c.cp = cp;
        return c;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.ts   = 6'(1) << (m_t - 1);
        e.cw   = model_cw(m_t, m_ir[7:4]);
        e.opnd = m_ir[3:0];
        q.push_back(e);
    endtask

    task automatic push_reset();
        exp_t e;
        e.ts   = 6'b000001;
        e.cw   = '0;
        e.opnd = 4'h0;
        q.push_back(e);
    endtask

    // One clock with the given bus value; leaves time at posedge+2 with expectation pushed.
    task automatic step(input logic [7:0] b);
        bus = b;
        @(posedge clk);
        if (m_t == 3) m_ir = b;
        if (!(m_t == 4 && m_ir[7:4] == 4'hF)) m_t = (m_t == 6) ? 1 : m_t + 1;
        #2;
        push_model();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            m_t   = 1;
            m_ir  = 8'h00;
            push_reset();
            #1;
            check(tstate == 6'b000001, "async_rst_tstate", 32'(tstate), 32'h1);
            check(dut_cw() == '0, "async_rst_ctrl", 32'(dut_cw()), 32'h0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        push_model();
    endtask

    task automatic run_instr(input logic [7:0] instr);
        for (int i = 0; i < 6; i++) begin
            if (m_t == 3) step(instr);
            else step(8'($urandom));
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            cw_t  a;
            int   drivers;
            e = q.pop_front();
            a = dut_cw();
            check(tstate == e.ts, "tstate", 32'(tstate), 32'(e.ts));
            check(a == e.cw, "control_word", 32'(a), 32'(e.cw));
            if (e.cw.ei) check(operand == e.opnd, "operand", 32'(operand), 32'(e.opnd));
            check($onehot(tstate), "tstate_onehot", 32'(tstate), 32'h1);
            drivers = int'(ep) + int'(er) + int'(ei) + int'(ea) + int'(eu);
            check(drivers <= 1, "single_bus_driver", 32'(drivers), 32'h1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        do_reset(2);
        run_instr(8'h05);          // LDA
        run_instr(8'h1A);          // ADD 0xA
        run_instr(8'h2C);          // SUB 0xC
        run_instr(8'hE0);          // OUT
        run_instr(8'h70);          // undefined -> NOP
        run_instr(8'h0F);          // LDA 0xF
        run_instr(8'hF0);          // HLT
        for (int i = 0; i < 22; i++) step(8'($urandom));
        do_reset(1);
        run_instr(8'h13);
        // Random instruction stream with occasional mid-instruction resets.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset(1);
            end else begin
                b = 8'($urandom);
                if (m_t == 3 && b[7:4] == 4'hF) b[7:4] = 4'h1;
                step(b);
            end
        end
        @(negedge clk);
        #1;
        check(q.size() == 0, "scoreboard_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
